// File: rtl/fft_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : fft_seq_ctrl_if
// Brief   : Handshake, configuration and status bundle for fft_seq_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
interface fft_seq_ctrl_if #(
    parameter int MAX_LOG2 = 10
);
    logic                start;
    logic                abort;
    logic [3:0]          nfft_log2;
    logic [7:0]          frames;
    logic                src_valid;
    logic                src_ready;
    logic                core_valid;
    logic                core_ready;
    logic                core_last;
    logic                res_valid;
    logic                res_ready;
    logic                res_last;
    logic [MAX_LOG2-1:0] res_index;
    logic                busy;
    logic                done;
    logic [7:0]          frames_done;
    logic                err_last;

    modport master (
        output start, abort, nfft_log2, frames, src_valid, core_ready,
               res_valid, res_ready, res_last,
        input  src_ready, core_valid, core_last, res_index, busy, done,
               frames_done, err_last
    );

    modport slave (
        input  start, abort, nfft_log2, frames, src_valid, core_ready,
               res_valid, res_ready, res_last,
        output src_ready, core_valid, core_last, res_index, busy, done,
               frames_done, err_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fft_seq_ctrl
// Brief   : Frame sequencer gating samples into the FFT core and tracking results.
// Revision: 1.0 - initial release
// ============================================================================
module fft_seq_ctrl #(
    parameter int MAX_LOG2     = 10,
    parameter int MAX_INFLIGHT = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fft_seq_ctrl_if.slave       bus
);
    localparam int OW = $clog2(MAX_INFLIGHT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0]    C_MIN_LOG2 = 4'd3;
    localparam logic [3:0]    C_MAX_LOG2 = 4'(MAX_LOG2);
    localparam logic [OW-1:0] C_MAX_INFL = OW'(MAX_INFLIGHT);

    logic [1:0]          r_state;
    logic [3:0]          r_nlog2;
    logic [7:0]          r_frames;
    logic [MAX_LOG2-1:0] r_in_cnt;
    logic [MAX_LOG2-1:0] r_out_cnt;
    logic [7:0]          r_issued;
    logic [OW-1:0]       r_outstanding;
    logic [7:0]          r_frames_done;
    logic                r_err_last;

    logic [3:0]          w_nlog2_clamped;
    logic [MAX_LOG2-1:0] w_last_idx;
    logic                w_load;
    logic                w_res_active;
    logic                w_gate;
    logic                w_in_fire;
    logic                w_in_last;
    logic                w_in_wrap;
    logic                w_res_fire;
    logic                w_out_last;
    logic                w_res_wrap;

    always_comb begin
        w_nlog2_clamped = bus.nfft_log2;
        if (bus.nfft_log2 < C_MIN_LOG2)
            w_nlog2_clamped = C_MIN_LOG2;
        else if (bus.nfft_log2 > C_MAX_LOG2)
            w_nlog2_clamped = C_MAX_LOG2;
    end

    // N-1 is simply the low nlog2 bits set.
    always_comb begin
        w_last_idx = '0;
        for (int i = 0; i < MAX_LOG2; i++)
            w_last_idx[i] = (4'(i) < r_nlog2);
    end

    assign w_load       = (r_state == S_LOAD);
    assign w_res_active = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign w_gate       = (r_outstanding < C_MAX_INFL);

    assign bus.core_valid = bus.src_valid  & w_gate & w_load;
    assign bus.src_ready  = bus.core_ready & w_gate & w_load;

    assign w_in_fire     = bus.core_valid & bus.core_ready;
    assign w_in_last     = (r_in_cnt == w_last_idx);
    assign w_in_wrap     = w_in_fire & w_in_last;
    assign bus.core_last = bus.core_valid & w_in_last;

    assign w_res_fire = bus.res_valid & bus.res_ready & w_res_active;
    assign w_out_last = (r_out_cnt == w_last_idx);
    assign w_res_wrap = w_res_fire & w_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_nlog2       <= C_MIN_LOG2;
            r_frames      <= '0;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_frames_done <= '0;
            r_err_last    <= 1'b0;
        end else if (bus.abort) begin
            r_state       <= S_IDLE;
            r_in_cnt      <= '0;
            r_out_cnt     <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_nlog2       <= w_nlog2_clamped;
                        r_frames      <= bus.frames;
                        r_in_cnt      <= '0;
                        r_out_cnt     <= '0;
                        r_issued      <= '0;
                        r_outstanding <= '0;
                        r_frames_done <= '0;
                        r_err_last    <= 1'b0;
                        r_state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_in_wrap && (r_frames != 8'd0) &&
                        ((r_issued + 8'd1) == r_frames))
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (r_outstanding == '0)
                        r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Fire strobes are gated off in IDLE, so these never collide with start.
            if (w_in_fire)
                r_in_cnt <= w_in_last ? '0 : r_in_cnt + 1'b1;
            if (w_in_wrap)
                r_issued <= r_issued + 8'd1;

            if (w_res_fire) begin
                r_out_cnt <= w_out_last ? '0 : r_out_cnt + 1'b1;
                if (bus.res_last != w_out_last)
                    r_err_last <= 1'b1;
            end
            if (w_res_wrap && (r_frames_done != 8'hFF))
                r_frames_done <= r_frames_done + 8'd1;

            if (w_in_wrap && !w_res_wrap)
                r_outstanding <= r_outstanding + OW'(1);
            else if (!w_in_wrap && w_res_wrap && (r_outstanding != '0))
                r_outstanding <= r_outstanding - OW'(1);
        end
    end

    assign bus.res_index   = r_out_cnt;
    assign bus.busy        = w_res_active;
    assign bus.done        = (r_state == S_DONE);
    assign bus.frames_done = r_frames_done;
    assign bus.err_last    = r_err_last;

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fft_seq_ctrl
// Brief   : Directed self-checking bench for fft_seq_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fft_seq_ctrl;
    localparam int MAX_LOG2 = 10;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fft_seq_ctrl_if #(.MAX_LOG2(MAX_LOG2)) bus ();

    fft_seq_ctrl #(.MAX_LOG2(MAX_LOG2), .MAX_INFLIGHT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [3:0] nl, input logic [7:0] nf);
        bus.nfft_log2 = nl;
        bus.frames    = nf;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    initial begin
        int acc;
        int bad;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start = 0; bus.abort = 0; bus.nfft_log2 = 0; bus.frames = 0;
        bus.src_valid = 0; bus.core_ready = 0;
        bus.res_valid = 0; bus.res_ready = 0; bus.res_last = 0;
        tick(); tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_src_ready", 32'(bus.src_ready), 0);
        check("rst_index", 32'(bus.res_index), 0);
        check("rst_frames_done", 32'(bus.frames_done), 0);
        check("rst_err", 32'(bus.err_last), 0);
        rst_n = 1'b1;
        tick();

        // Single 8-point frame
        start_run(4'd3, 8'd1);
        check("t1_busy_load", 32'(bus.busy), 1);
        bus.src_valid = 1; bus.core_ready = 1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (bus.core_valid !== 1'b1 || bus.core_last !== (i == 7)) bad++;
            tick();
        end
        check("t1_last_pattern", 32'(bad), 0);
        #1;
        check("t1_drain_valid", 32'(bus.core_valid), 0);
        check("t1_drain_busy", 32'(bus.busy), 1);
        bus.src_valid = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            bus.res_valid = 1; bus.res_ready = 1; bus.res_last = (i == 7);
            #1;
            if (bus.res_index !== 10'(i)) bad++;
            tick();
        end
        check("t1_res_index", 32'(bad), 0);
        bus.res_valid = 0; bus.res_last = 0;
        #1;
        check("t1_done_early", 32'(bus.done), 0);
        tick();
        check("t1_done", 32'(bus.done), 1);
        check("t1_frames_done", 32'(bus.frames_done), 1);
        check("t1_err", 32'(bus.err_last), 0);
        tick();
        check("t1_done_once", 32'(bus.done), 0);
        check("t1_idle", 32'(bus.busy), 0);

        // In-flight limit
        start_run(4'd4, 8'd4);
        bus.src_valid = 1; bus.core_ready = 1;
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.src_ready === 1'b1) acc++;
            tick();
        end
        check("t2_accepted", 32'(acc), 32);
        check("t2_blocked", 32'(bus.src_ready), 0);
        for (int i = 0; i < 16; i++) begin
            bus.res_valid = 1; bus.res_ready = 1; bus.res_last = (i == 15);
            #1;
            if (i == 15) check("t2_still_blocked", 32'(bus.src_ready), 0);
            tick();
        end
        bus.res_valid = 0; bus.res_last = 0;
        #1;
        check("t2_reopen", 32'(bus.src_ready), 1);
        check("t2_frames_done", 32'(bus.frames_done), 1);
        bus.src_valid = 0;
        bus.abort = 1;
        tick();
        bus.abort = 0;
        check("t2_abort_idle", 32'(bus.busy), 0);

        // Framing error at index 5
        start_run(4'd3, 8'd1);
        check("t3_err_cleared", 32'(bus.err_last), 0);
        bus.src_valid = 1;
        for (int i = 0; i < 8; i++) tick();
        bus.src_valid = 0;
        for (int i = 0; i < 8; i++) begin
            bus.res_valid = 1; bus.res_ready = 1; bus.res_last = (i == 5);
            #1;
            if (i == 5) check("t3_err_before", 32'(bus.err_last), 0);
            if (i == 6) check("t3_err_after", 32'(bus.err_last), 1);
            tick();
        end
        bus.res_valid = 0; bus.res_last = 0;
        tick();
        check("t3_done", 32'(bus.done), 1);
        check("t3_err_held", 32'(bus.err_last), 1);
        check("t3_frames_done", 32'(bus.frames_done), 1);
        tick();

        // Clamp + continuous mode with simultaneous wraps
        start_run(4'd1, 8'd0);
        check("t4_err_cleared", 32'(bus.err_last), 0);
        check("t4_fd_cleared", 32'(bus.frames_done), 0);
        bus.src_valid = 1; bus.core_ready = 1; bus.res_ready = 1;
        bad = 0;
        acc = 0;
        for (int c = 0; c < 88; c++) begin
            bus.res_valid = (c >= 8);
            bus.res_last  = (c >= 8) && (((c - 8) % 8) == 7);
            #1;
            if (bus.core_last !== ((c % 8) == 7)) bad++;
            if (bus.src_ready !== 1'b1) acc++;
            tick();
        end
        check("t4_last_every8", 32'(bad), 0);
        check("t4_ready_held", 32'(acc), 0);
        bus.res_valid = 0; bus.res_last = 0;
        #1;
        check("t4_still_load", 32'(bus.src_ready), 1);
        check("t4_frames_done", 32'(bus.frames_done), 10);
        bus.src_valid = 0;
        bus.abort = 1;
        tick();
        bus.abort = 0;
        check("t4_abort_idle", 32'(bus.busy), 0);
        check("t4_abort_nodone", 32'(bus.done), 0);
        tick();
        check("t4_abort_nodone2", 32'(bus.done), 0);
        check("t4_fd_kept", 32'(bus.frames_done), 10);

        // Reset in the middle of a 1024-point frame
        start_run(4'd10, 8'd1);
        bus.src_valid = 1;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(bus.src_ready), 0);
        check("t5_rst_valid", 32'(bus.core_valid), 0);
        check("t5_rst_busy", 32'(bus.busy), 0);
        check("t5_rst_fd", 32'(bus.frames_done), 0);
        bus.src_valid = 0;
        tick();
        rst_n = 1'b1;
        tick();
        start_run(4'd10, 8'd1);
        bus.src_valid = 1;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            #1;
            if (bus.core_last !== (i == 1023)) bad++;
            tick();
        end
        check("t5_last_1024", 32'(bad), 0);
        bus.src_valid = 0;
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            bus.res_valid = 1; bus.res_last = (i == 1023);
            #1;
            if (bus.res_index !== 10'(i)) bad++;
            tick();
        end
        check("t5_index_seq", 32'(bad), 0);
        bus.res_valid = 0; bus.res_last = 0;
        tick();
        check("t5_done", 32'(bus.done), 1);
        check("t5_err", 32'(bus.err_last), 0);
        check("t5_frames_done", 32'(bus.frames_done), 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
